mem_id_arbiter: RTL and testbench

//  Shares one single-port TCM/memory port between riscv_core's instruction-fetch (mem_i_*) and data (mem_d_*) interfaces.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_resp_fifo.sv | 73 +++++++
 rtl/mem_id_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_id_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory arbiter: source identifiers and the
// in-flight bookkeeping entry kept for every accepted transaction.
package mem_arb_pkg;

    localparam int TAG_W = 11;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    // One outstanding transaction: who issued it, whether it completes locally
    // (cache-maintenance op, never sent downstream) and the D request tag.
    typedef struct packed {
        logic             src;
        logic             is_local;
        logic [TAG_W-1:0] tag;
    } arb_entry_t;

endpackage

// File: rtl/mem_arb_resp_fifo.sv
// In-order tracking FIFO for outstanding arbiter transactions. The head entry
// is visible combinationally so the arbiter can route the matching response.
module mem_arb_resp_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  arb_entry_t push_data_i,
    input  logic       pop_i,
    output arb_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    arb_entry_t       slot_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_push;
    logic             do_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    always_comb begin
        full_o      = (count_reg == CNT_W'(DEPTH));
        empty_o     = (count_reg == '0);
        do_push     = push_i && !full_o;
        do_pop      = pop_i && !empty_o;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        head_o = slot_reg[rd_ptr_reg];
    end

    // Pointer and occupancy state; contents are discarded on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Per-slot storage write; slot payload needs no reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk_i) begin
            if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                slot_reg[gi] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/mem_id_arbiter.sv
// Shares one single-port memory between the core's fetch (I) and data (D)
// interfaces. Requests are arbitrated combinationally; every accepted
// transaction is tracked in order so the in-order downstream acks can be
// routed back to the issuing side. D maintenance ops complete locally.
module mem_id_arbiter
#(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_i_rd_i,
    input  logic        mem_i_flush_i,
    input  logic        mem_i_invalidate_i,
    input  logic [31:0] mem_i_pc_i,
    output logic        mem_i_accept_o,
    output logic        mem_i_valid_o,
    output logic        mem_i_error_o,
    output logic [31:0] mem_i_inst_o,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic        mem_d_rd_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_cacheable_i,
    input  logic [10:0] mem_d_req_tag_i,
    input  logic        mem_d_invalidate_i,
    input  logic        mem_d_writeback_i,
    input  logic        mem_d_flush_i,
    output logic        mem_d_accept_o,
    output logic        mem_d_ack_o,
    output logic        mem_d_error_o,
    output logic [31:0] mem_d_data_rd_o,
    output logic [10:0] mem_d_resp_tag_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_data_rd_i,
    output logic        proto_err_o
);

    import mem_arb_pkg::*;

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;

    logic        i_req, d_req, d_maint, d_active, starve_full;
    logic        grant_i, grant_d, dn_i, dn_d;
    logic        issue_i, issue_d, maint_accept;
    logic        fifo_full, fifo_empty, push, pop_local, pop_ack, ack_orphan;
    arb_entry_t  push_entry, head_entry;
    logic        resp_i, resp_d;

    logic        i_valid_reg, i_error_reg;
    logic [31:0] i_inst_reg;
    logic        d_ack_reg, d_error_reg;
    logic [31:0] d_data_reg;
    logic [10:0] d_tag_reg;
    logic        proto_err_reg;

    // Cache hints have no meaning here: no cache sits behind the arbiter.
    logic unused_hints;
    assign unused_hints = ^{mem_i_flush_i, mem_i_invalidate_i, mem_d_cacheable_i};

    // Grant, downstream request mux and accept handshakes.
    always_comb begin
        i_req       = mem_i_rd_i;
        d_req       = mem_d_rd_i || (|mem_d_wr_i);
        d_maint     = mem_d_invalidate_i || mem_d_writeback_i || mem_d_flush_i;
        d_active    = d_req || d_maint;
        starve_full = (starve_cnt_reg == STARVE_W'(STARVE_LIMIT));

        // D wins unless it is idle or I has been denied long enough.
        grant_i = !rst_i && i_req && (!d_active || starve_full);
        grant_d = !rst_i && d_active && !grant_i;

        // Nothing is offered downstream while there is no slot to track it.
        dn_i = grant_i && !fifo_full;
        dn_d = grant_d && d_req && !fifo_full;

        issue_i      = dn_i && mem_accept_i;
        issue_d      = dn_d && mem_accept_i;
        maint_accept = grant_d && !d_req && fifo_empty;

        mem_addr_o    = '0;
        mem_data_wr_o = '0;
        mem_rd_o      = 1'b0;
        mem_wr_o      = '0;
        if (dn_i) begin
            mem_addr_o = mem_i_pc_i;
            mem_rd_o   = 1'b1;
        end else if (dn_d) begin
            mem_addr_o    = mem_d_addr_i;
            mem_data_wr_o = mem_d_data_wr_i;
            mem_rd_o      = mem_d_rd_i;
            mem_wr_o      = mem_d_wr_i;
        end

        mem_i_accept_o = issue_i;
        mem_d_accept_o = issue_d || maint_accept;

        push                = issue_i || issue_d || maint_accept;
        push_entry.src      = issue_i ? SRC_I : SRC_D;
        push_entry.is_local = maint_accept;
        push_entry.tag      = issue_i ? '0 : mem_d_req_tag_i;

        // A local head retires on its own; its response was already issued.
        pop_local  = !fifo_empty && head_entry.is_local;
        pop_ack    = mem_ack_i && !fifo_empty && !head_entry.is_local;
        ack_orphan = mem_ack_i && fifo_empty;
        resp_i     = pop_ack && (head_entry.src == SRC_I);
        resp_d     = pop_ack && (head_entry.src == SRC_D);

        starve_cnt_next = starve_cnt_reg;
        if (issue_i) begin
            starve_cnt_next = '0;
        end else if (i_req && !grant_i && !starve_full) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    mem_arb_resp_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop_local || pop_ack),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Starvation counter and registered, single-cycle response pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_reg <= '0;
            i_valid_reg    <= 1'b0;
            i_error_reg    <= 1'b0;
            i_inst_reg     <= '0;
            d_ack_reg      <= 1'b0;
            d_error_reg    <= 1'b0;
            d_data_reg     <= '0;
            d_tag_reg      <= '0;
            proto_err_reg  <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            i_valid_reg    <= resp_i;
            i_error_reg    <= resp_i && mem_error_i;
            i_inst_reg     <= resp_i ? mem_data_rd_i : '0;
            // A maintenance op is only taken with nothing outstanding, so it
            // never collides with a downstream D response.
            d_ack_reg      <= resp_d || maint_accept;
            d_error_reg    <= resp_d && mem_error_i;
            d_data_reg     <= resp_d ? mem_data_rd_i : '0;
            d_tag_reg      <= maint_accept ? mem_d_req_tag_i :
                              (resp_d ? head_entry.tag : '0);
            proto_err_reg  <= proto_err_reg || ack_orphan;
        end
    end

    assign mem_i_valid_o    = i_valid_reg;
    assign mem_i_error_o    = i_error_reg;
    assign mem_i_inst_o     = i_inst_reg;
    assign mem_d_ack_o      = d_ack_reg;
    assign mem_d_error_o    = d_error_reg;
    assign mem_d_data_rd_o  = d_data_reg;
    assign mem_d_resp_tag_o = d_tag_reg;
    assign proto_err_o      = proto_err_reg;

endmodule

// File: tb/tb_mem_id_arbiter.sv
// Bench for mem_id_arbiter: directed scenarios plus a randomized run checked
// against a queue-based model of the arbitration and response-order rules.
module tb_mem_id_arbiter;

    localparam int OUTSTANDING  = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rd, i_flush, i_inv;
    logic [31:0] i_pc;
    logic        i_accept, i_valid, i_error;
    logic [31:0] i_inst;
    logic [31:0] d_addr, d_wdata;
    logic        d_rd;
    logic [3:0]  d_wr;
    logic        d_cach;
    logic [10:0] d_tag;
    logic        d_inv, d_wb, d_flush;
    logic        d_accept, d_ack, d_error;
    logic [31:0] d_rdata;
    logic [10:0] d_rtag;
    logic [31:0] m_addr, m_wdata;
    logic        m_rd;
    logic [3:0]  m_wr;
    logic        m_accept, m_ack, m_error;
    logic [31:0] m_rdata;
    logic        proto_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_id_arbiter #(
        .OUTSTANDING  (OUTSTANDING),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem_i_rd_i         (i_rd),
        .mem_i_flush_i      (i_flush),
        .mem_i_invalidate_i (i_inv),
        .mem_i_pc_i         (i_pc),
        .mem_i_accept_o     (i_accept),
        .mem_i_valid_o      (i_valid),
        .mem_i_error_o      (i_error),
        .mem_i_inst_o       (i_inst),
        .mem_d_addr_i       (d_addr),
        .mem_d_data_wr_i    (d_wdata),
        .mem_d_rd_i         (d_rd),
        .mem_d_wr_i         (d_wr),
        .mem_d_cacheable_i  (d_cach),
        .mem_d_req_tag_i    (d_tag),
        .mem_d_invalidate_i (d_inv),
        .mem_d_writeback_i  (d_wb),
        .mem_d_flush_i      (d_flush),
        .mem_d_accept_o     (d_accept),
        .mem_d_ack_o        (d_ack),
        .mem_d_error_o      (d_error),
        .mem_d_data_rd_o    (d_rdata),
        .mem_d_resp_tag_o   (d_rtag),
        .mem_addr_o         (m_addr),
        .mem_data_wr_o      (m_wdata),
        .mem_rd_o           (m_rd),
        .mem_wr_o           (m_wr),
        .mem_accept_i       (m_accept),
        .mem_ack_i          (m_ack),
        .mem_error_i        (m_error),
        .mem_data_rd_i      (m_rdata),
        .proto_err_o        (proto_err)
    );

    // Inputs change 1 time unit after the rising edge; checks run at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rd = 0; i_flush = 0; i_inv = 0; i_pc = '0;
        d_addr = '0; d_wdata = '0; d_rd = 0; d_wr = '0; d_cach = 0; d_tag = '0;
        d_inv = 0; d_wb = 0; d_flush = 0;
        m_accept = 0; m_ack = 0; m_error = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        i_rd = 1; d_rd = 1; m_accept = 1; i_pc = 32'h8000_0000;
        tick();
        #4;
        total++; if (i_accept !== 1'b0) begin bad++; $display("FAIL reset_i_accept got=%b want=0", i_accept); end
        total++; if (d_accept !== 1'b0) begin bad++; $display("FAIL reset_d_accept got=%b want=0", d_accept); end
        total++; if (m_rd !== 1'b0 || m_wr !== 4'h0) begin bad++; $display("FAIL reset_mem_req got rd=%b wr=%h want 0", m_rd, m_wr); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", m_addr); end
        total++; if (i_valid !== 1'b0 || d_ack !== 1'b0) begin bad++; $display("FAIL reset_resp got iv=%b da=%b want 0", i_valid, d_ack); end
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto got=%b want=0", proto_err); end
        total++; if (d_rtag !== 11'h0 || i_inst !== 32'h0) begin bad++; $display("FAIL reset_data got tag=%h inst=%h want 0", d_rtag, i_inst); end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_fetch_single();
        do_reset();
        m_accept = 1; i_rd = 1; i_pc = 32'h8000_0000;
        #4;
        total++; if (i_accept !== 1'b1) begin bad++; $display("FAIL fetch_accept got=%b want=1", i_accept); end
        total++; if (m_rd !== 1'b1 || m_wr !== 4'h0 || m_addr !== 32'h8000_0000 || m_wdata !== 32'h0)
            begin bad++; $display("FAIL fetch_mem_req got rd=%b wr=%h addr=%h wd=%h want 1/0/80000000/0", m_rd, m_wr, m_addr, m_wdata); end
        tick();
        i_rd = 0; m_ack = 1; m_rdata = 32'hDEAD_BEEF;
        #4;
        total++; if (i_valid !== 1'b0) begin bad++; $display("FAIL fetch_early_valid got=%b want=0", i_valid); end
        tick();
        m_ack = 0; m_rdata = '0;
        #4;
        total++; if (i_valid !== 1'b1 || i_inst !== 32'hDEAD_BEEF || i_error !== 1'b0)
            begin bad++; $display("FAIL fetch_resp got v=%b inst=%h e=%b want 1/deadbeef/0", i_valid, i_inst, i_error); end
        tick();
        #4;
        total++; if (i_valid !== 1'b0) begin bad++; $display("FAIL fetch_pulse got=%b want=0", i_valid); end
        tick();
    endtask

    task automatic test_d_over_i();
        do_reset();
        m_accept = 1;
        d_rd = 1; d_addr = 32'h0000_1000; d_tag = 11'h123;
        i_rd = 1; i_pc = 32'h8000_0004;
        #4;
        total++; if (d_accept !== 1'b1 || i_accept !== 1'b0) begin bad++; $display("FAIL dvi_first got d=%b i=%b want d=1 i=0", d_accept, i_accept); end
        total++; if (m_addr !== 32'h0000_1000) begin bad++; $display("FAIL dvi_first_addr got=%h want=00001000", m_addr); end
        tick();
        d_rd = 0; m_ack = 1; m_rdata = 32'h1111_1111;
        #4;
        total++; if (i_accept !== 1'b1 || m_addr !== 32'h8000_0004) begin bad++; $display("FAIL dvi_second got i=%b addr=%h want 1/80000004", i_accept, m_addr); end
        tick();
        i_rd = 0; m_ack = 1; m_rdata = 32'h2222_2222;
        #4;
        total++; if (d_ack !== 1'b1 || d_rtag !== 11'h123 || d_rdata !== 32'h1111_1111 || i_valid !== 1'b0)
            begin bad++; $display("FAIL dvi_d_resp got ack=%b tag=%h data=%h iv=%b want 1/123/11111111/0", d_ack, d_rtag, d_rdata, i_valid); end
        tick();
        m_ack = 0; m_rdata = '0;
        #4;
        total++; if (i_valid !== 1'b1 || i_inst !== 32'h2222_2222 || d_ack !== 1'b0)
            begin bad++; $display("FAIL dvi_i_resp got iv=%b inst=%h da=%b want 1/22222222/0", i_valid, i_inst, d_ack); end
        tick();
    endtask

    task automatic test_starvation();
        int  first_i  = -1;
        int  second_i = -1;
        bit  prev_acc = 0;
        do_reset();
        m_accept = 1;
        for (int c = 0; c < 20; c++) begin
            m_ack = prev_acc; m_rdata = $urandom;
            i_rd = 1; i_pc = 32'h8000_0100;
            d_rd = 1; d_addr = 32'h2000 + 32'(c); d_tag = 11'(c);
            #4;
            if (i_accept === 1'b1) begin
                if (first_i < 0) first_i = c;
                else if (second_i < 0) second_i = c;
            end
            prev_acc = (i_accept === 1'b1) || (d_accept === 1'b1);
            if (second_i >= 0) break;
            tick();
        end
        total++; if (first_i != STARVE_LIMIT) begin bad++; $display("FAIL starve_first got cycle=%0d want=%0d", first_i, STARVE_LIMIT); end
        total++; if (second_i - first_i != STARVE_LIMIT + 1) begin bad++; $display("FAIL starve_clear got gap=%0d want=%0d", second_i - first_i, STARVE_LIMIT + 1); end
        tick();
        i_rd = 0; d_rd = 0; m_ack = prev_acc;
        tick();
        m_ack = 0;
        tick();
    endtask

    task automatic test_fifo_full();
        do_reset();
        m_accept = 1;
        d_rd = 1; d_addr = 32'h100; d_tag = 11'd1;
        #4;
        total++; if (d_accept !== 1'b1) begin bad++; $display("FAIL full_acc1 got=%b want=1", d_accept); end
        tick();
        d_tag = 11'd2;
        #4;
        total++; if (d_accept !== 1'b1) begin bad++; $display("FAIL full_acc2 got=%b want=1", d_accept); end
        tick();
        d_tag = 11'd3; i_rd = 1; i_pc = 32'h8000_0010;
        #4;
        total++; if (d_accept !== 1'b0 || i_accept !== 1'b0 || m_rd !== 1'b0)
            begin bad++; $display("FAIL full_block got d=%b i=%b rd=%b want 0/0/0", d_accept, i_accept, m_rd); end
        tick();
        i_rd = 0; m_ack = 1; m_rdata = 32'hA1;
        #4;
        total++; if (d_accept !== 1'b0) begin bad++; $display("FAIL full_pop_same got=%b want=0", d_accept); end
        tick();
        m_ack = 0;
        #4;
        total++; if (d_accept !== 1'b1) begin bad++; $display("FAIL full_after_pop got=%b want=1", d_accept); end
        total++; if (d_ack !== 1'b1 || d_rtag !== 11'd1 || d_rdata !== 32'hA1)
            begin bad++; $display("FAIL full_resp1 got ack=%b tag=%h data=%h want 1/001/a1", d_ack, d_rtag, d_rdata); end
        tick();
        d_rd = 0; m_ack = 1; m_rdata = 32'hA2;
        tick();
        m_rdata = 32'hA3;
        #4;
        total++; if (d_ack !== 1'b1 || d_rtag !== 11'd2) begin bad++; $display("FAIL full_resp2 got ack=%b tag=%h want 1/002", d_ack, d_rtag); end
        tick();
        m_ack = 0;
        #4;
        total++; if (d_ack !== 1'b1 || d_rtag !== 11'd3 || d_rdata !== 32'hA3)
            begin bad++; $display("FAIL full_resp3 got ack=%b tag=%h data=%h want 1/003/a3", d_ack, d_rtag, d_rdata); end
        tick();
    endtask

    task automatic test_maint();
        do_reset();
        m_accept = 1;
        d_flush = 1; d_tag = 11'h7FF;
        #4;
        total++; if (d_accept !== 1'b1) begin bad++; $display("FAIL maint_accept got=%b want=1", d_accept); end
        total++; if (m_rd !== 1'b0 || m_wr !== 4'h0) begin bad++; $display("FAIL maint_no_mem got rd=%b wr=%h want 0/0", m_rd, m_wr); end
        tick();
        d_flush = 0; d_tag = '0;
        #4;
        total++; if (d_ack !== 1'b1 || d_rtag !== 11'h7FF || d_rdata !== 32'h0 || d_error !== 1'b0)
            begin bad++; $display("FAIL maint_resp got ack=%b tag=%h data=%h e=%b want 1/7ff/0/0", d_ack, d_rtag, d_rdata, d_error); end
        total++; if (m_rd !== 1'b0 || m_wr !== 4'h0) begin bad++; $display("FAIL maint_quiet got rd=%b wr=%h want 0/0", m_rd, m_wr); end
        tick();
        #4;
        total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL maint_pulse got=%b want=0", d_ack); end
        d_rd = 1; d_tag = 11'h5;
        tick();
        d_rd = 0; d_inv = 1; d_tag = 11'h6;
        #4;
        total++; if (d_accept !== 1'b0) begin bad++; $display("FAIL maint_busy got=%b want=0", d_accept); end
        tick();
        d_inv = 0; m_ack = 1; m_rdata = 32'h55;
        tick();
        m_ack = 0;
        #4;
        total++; if (d_ack !== 1'b1 || d_rtag !== 11'h5) begin bad++; $display("FAIL maint_busy_resp got ack=%b tag=%h want 1/005", d_ack, d_rtag); end
        tick();
    endtask

    task automatic test_proto_and_reset();
        do_reset();
        m_accept = 1; i_rd = 1; i_pc = 32'h8000_0200;
        #4;
        total++; if (i_accept !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b want=1", i_accept); end
        tick();
        i_rd = 0; rst = 1; m_ack = 1; m_rdata = 32'h1234_5678;
        tick();
        rst = 0; m_ack = 0;
        #4;
        total++; if (i_valid !== 1'b0 || i_inst !== 32'h0 || d_ack !== 1'b0 || proto_err !== 1'b0 || m_rd !== 1'b0)
            begin bad++; $display("FAIL rstmid_outputs got iv=%b inst=%h da=%b pe=%b rd=%b want all 0", i_valid, i_inst, d_ack, proto_err, m_rd); end
        tick();
        m_ack = 1; m_rdata = 32'hBAD0_BAD0;
        #4;
        total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL proto_early got=%b want=0", proto_err); end
        tick();
        m_ack = 0;
        #4;
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_set got=%b want=1", proto_err); end
        total++; if (i_valid !== 1'b0 || d_ack !== 1'b0) begin bad++; $display("FAIL proto_dropped got iv=%b da=%b want 0/0", i_valid, d_ack); end
        tick();
        tick();
        tick();
        #4;
        total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b want=1", proto_err); end
        tick();
    endtask

    typedef struct {
        bit        src_d;
        bit        loc;
        bit [10:0] tag;
    } m_ent_t;

    task automatic test_random();
        m_ent_t    mq[$];
        m_ent_t    e;
        int        starve = 0;
        int        pend   = 0;
        int        op;
        bit        pe_cur = 0, pe_nxt;
        bit        iv_cur = 0, ie_cur = 0, da_cur = 0, de_cur = 0;
        bit [31:0] ii_cur = 0, dd_cur = 0;
        bit [10:0] dt_cur = 0;
        bit        iv_nxt, ie_nxt, da_nxt, de_nxt;
        bit [31:0] ii_nxt, dd_nxt;
        bit [10:0] dt_nxt;
        bit        ireq, dreq, dmaint, dact, full, empty, iwin;
        bit        e_iacc, e_ddn, e_maint, e_rd;
        bit [3:0]  e_wr;
        bit [31:0] e_addr, e_wd;
        bit        have_req;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            i_rd = 1'($urandom_range(0, 1));
            i_pc = $urandom;
            op = $urandom_range(0, 7);
            d_addr = $urandom; d_wdata = $urandom; d_tag = 11'($urandom);
            d_cach = 1'($urandom_range(0, 1));
            if (op == 3 || op == 4) d_rd = 1;
            if (op == 5 || op == 6) d_wr = 4'($urandom_range(1, 15));
            if (op == 7) begin
                case ($urandom_range(0, 2))
                    0: d_inv = 1;
                    1: d_wb = 1;
                    default: d_flush = 1;
                endcase
            end
            m_accept = ($urandom_range(0, 3) != 0);
            m_ack    = (pend > 0) && ($urandom_range(0, 1) == 1);
            m_rdata  = $urandom;
            m_error  = ($urandom_range(0, 7) == 0);
            #4;
            // Registered responses predicted in the previous cycle.
            total++; if (i_valid !== iv_cur) begin bad++; $display("FAIL rnd_i_valid c=%0d got=%b want=%b", c, i_valid, iv_cur); end
            if (iv_cur) begin
                total++; if (i_inst !== ii_cur || i_error !== ie_cur) begin bad++; $display("FAIL rnd_i_data c=%0d got=%h/%b want=%h/%b", c, i_inst, i_error, ii_cur, ie_cur); end
            end
            total++; if (d_ack !== da_cur) begin bad++; $display("FAIL rnd_d_ack c=%0d got=%b want=%b", c, d_ack, da_cur); end
            if (da_cur) begin
                total++; if (d_rdata !== dd_cur || d_error !== de_cur || d_rtag !== dt_cur)
                    begin bad++; $display("FAIL rnd_d_data c=%0d got=%h/%b/%h want=%h/%b/%h", c, d_rdata, d_error, d_rtag, dd_cur, de_cur, dt_cur); end
            end
            total++; if (proto_err !== pe_cur) begin bad++; $display("FAIL rnd_proto c=%0d got=%b want=%b", c, proto_err, pe_cur); end
            // Arbitration rules applied to the current inputs and model state.
            ireq   = i_rd;
            dreq   = d_rd || (d_wr != 0);
            dmaint = d_inv || d_wb || d_flush;
            dact   = dreq || dmaint;
            full   = (mq.size() == OUTSTANDING);
            empty  = (mq.size() == 0);
            iwin   = ireq && (!dact || starve == STARVE_LIMIT);
            e_rd = 0; e_wr = 0; e_addr = 0; e_wd = 0; have_req = 0;
            if (iwin && !full) begin
                e_rd = 1; e_addr = i_pc; have_req = 1;
            end else if (!iwin && dreq && !full) begin
                e_rd = d_rd; e_wr = d_wr; e_addr = d_addr; e_wd = d_wdata; have_req = 1;
            end
            e_iacc  = iwin && !full && m_accept;
            e_ddn   = !iwin && dreq && !full && m_accept;
            e_maint = !iwin && dmaint && !dreq && empty;
            total++; if (i_accept !== e_iacc) begin bad++; $display("FAIL rnd_i_accept c=%0d got=%b want=%b", c, i_accept, e_iacc); end
            total++; if (d_accept !== (e_ddn || e_maint)) begin bad++; $display("FAIL rnd_d_accept c=%0d got=%b want=%b", c, d_accept, e_ddn || e_maint); end
            total++; if (m_rd !== e_rd || m_wr !== e_wr) begin bad++; $display("FAIL rnd_mem_req c=%0d got=%b/%h want=%b/%h", c, m_rd, m_wr, e_rd, e_wr); end
            if (have_req) begin
                total++; if (m_addr !== e_addr || m_wdata !== e_wd) begin bad++; $display("FAIL rnd_mem_addr c=%0d got=%h/%h want=%h/%h", c, m_addr, m_wdata, e_addr, e_wd); end
            end
            // Response ordering and the state seen after this edge.
            iv_nxt = 0; ie_nxt = 0; ii_nxt = 0; da_nxt = 0; de_nxt = 0; dd_nxt = 0; dt_nxt = 0;
            pe_nxt = pe_cur;
            if (mq.size() > 0 && mq[0].loc) begin
                void'(mq.pop_front());
            end else if (m_ack) begin
                if (mq.size() == 0) begin
                    pe_nxt = 1;
                end else begin
                    e = mq.pop_front();
                    if (e.src_d) begin
                        da_nxt = 1; dd_nxt = m_rdata; de_nxt = m_error; dt_nxt = e.tag;
                    end else begin
                        iv_nxt = 1; ii_nxt = m_rdata; ie_nxt = m_error;
                    end
                end
            end
            if (e_maint) begin
                da_nxt = 1; dt_nxt = d_tag;
                mq.push_back('{src_d: 1, loc: 1, tag: d_tag});
            end
            if (e_iacc) mq.push_back('{src_d: 0, loc: 0, tag: 11'h0});
            if (e_ddn)  mq.push_back('{src_d: 1, loc: 0, tag: d_tag});
            if (e_iacc || e_ddn) pend++;
            if (m_ack) pend--;
            if (e_iacc) starve = 0;
            else if (ireq && !iwin && starve < STARVE_LIMIT) starve++;
            tick();
            iv_cur = iv_nxt; ie_cur = ie_nxt; ii_cur = ii_nxt;
            da_cur = da_nxt; de_cur = de_nxt; dd_cur = dd_nxt; dt_cur = dt_nxt;
            pe_cur = pe_nxt;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_fetch_single();
        test_d_over_i();
        test_starvation();
        test_fifo_full();
        test_maint();
        test_proto_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
